// File: rtl/lagarto_plic_pkg.sv
// rtl/lagarto_plic_pkg.sv - Shared types and constants for the Lagarto PLIC.
package lagarto_plic_pkg;

    localparam int unsigned INTERRUPT_ID_WIDTH = 5;

    typedef logic [INTERRUPT_ID_WIDTH-1:0] interrupt_id_t;

    localparam interrupt_id_t NO_INTERRUPT_ID = '0;

    localparam int unsigned DEFAULT_CLAIM_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLAIMED  = 2'd1,
        COMPLETE = 2'd2
    } plic_target_state_t;

endpackage

// File: rtl/lagarto_plic_claim_timer.sv
// rtl/lagarto_plic_claim_timer.sv - Open-claim age counter with expiry strobe.
// Only instantiated when LAGARTO_PLIC_CLAIM_TIMEOUT_EN is defined.
module lagarto_plic_claim_timer
    import lagarto_plic_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_CLAIM_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] r_count;

    // Saturates at the last count so a stalled claim never wraps back to zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (start_i && (r_count != LAST_COUNT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire_o = start_i && !clear_i && (r_count == LAST_COUNT);

endmodule

// File: rtl/lagarto_plic_target.sv
// rtl/lagarto_plic_target.sv - Hart-side PLIC claim/complete controller.
// Optional forced completion of stale claims under LAGARTO_PLIC_CLAIM_TIMEOUT_EN.
module lagarto_plic_target
    import lagarto_plic_pkg::*;
#(
    parameter int unsigned NUMBER_OF_INTERRUPT_SOURCES = 2,
    parameter int unsigned CLAIM_TIMEOUT_CYCLES        = DEFAULT_CLAIM_TIMEOUT_CYCLES
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          interrupt_notification_i,
    input  interrupt_id_t interrupt_id_i,
    output logic          interrupt_claim_complete_o,
    output logic          meip_o,
    input  logic          claim_req_i,
    output logic          claim_valid_o,
    output interrupt_id_t claim_id_o,
    input  logic          complete_req_i,
    input  interrupt_id_t complete_id_i,
    output logic          complete_ack_o,
    output logic          timeout_o
);

    localparam interrupt_id_t MAX_ID = interrupt_id_t'(NUMBER_OF_INTERRUPT_SOURCES);

    plic_target_state_t r_state;
    plic_target_state_t w_state_d;
    interrupt_id_t      r_claimed_id;
    interrupt_id_t      w_claimed_id_d;
    interrupt_id_t      r_claim_id;
    interrupt_id_t      w_claim_id_d;
    logic               r_claim_valid;
    logic               r_complete_ack;
    logic               r_meip;
    logic               w_id_legal;
    logic               w_grant;
    logic               w_match;
    logic               w_expire;
    logic               w_force;

    assign w_id_legal = (interrupt_id_i != NO_INTERRUPT_ID) && (interrupt_id_i <= MAX_ID);

    // A simultaneous complete wins; the claim is then answered with no ID.
    assign w_grant = claim_req_i && !complete_req_i && (r_state != CLAIMED)
                     && interrupt_notification_i && w_id_legal;

    assign w_match = complete_req_i && (r_state == CLAIMED) && (complete_id_i == r_claimed_id);
    assign w_force = (r_state == CLAIMED) && w_expire && !w_match;

    assign w_claim_id_d = w_grant ? interrupt_id_i : NO_INTERRUPT_ID;

    always_comb begin
        w_state_d      = r_state;
        w_claimed_id_d = r_claimed_id;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_d      = CLAIMED;
                    w_claimed_id_d = interrupt_id_i;
                end
            end
            CLAIMED: begin
                if (w_match || w_expire) begin
                    w_state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                if (w_grant) begin
                    w_state_d      = CLAIMED;
                    w_claimed_id_d = interrupt_id_i;
                end else begin
                    w_state_d      = IDLE;
                    w_claimed_id_d = NO_INTERRUPT_ID;
                end
            end
            default: begin
                w_state_d      = IDLE;
                w_claimed_id_d = NO_INTERRUPT_ID;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_claimed_id   <= NO_INTERRUPT_ID;
            r_claim_id     <= NO_INTERRUPT_ID;
            r_claim_valid  <= 1'b0;
            r_complete_ack <= 1'b0;
            r_meip         <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_claimed_id   <= w_claimed_id_d;
            r_claim_valid  <= claim_req_i;
            r_complete_ack <= complete_req_i;
            if (claim_req_i) begin
                r_claim_id <= w_claim_id_d;
            end
            // Qualifying with the next state keeps meip low for the whole claim.
            r_meip <= interrupt_notification_i && (w_state_d == IDLE);
        end
    end

`ifdef LAGARTO_PLIC_CLAIM_TIMEOUT_EN
    logic r_timeout;

    lagarto_plic_claim_timer #(
        .TIMEOUT_CYCLES (CLAIM_TIMEOUT_CYCLES)
    ) u_claim_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (r_state == CLAIMED),
        .clear_i  (r_state != CLAIMED),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if (w_force) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign interrupt_claim_complete_o = (r_state == COMPLETE);
    assign meip_o                     = r_meip;
    assign claim_valid_o              = r_claim_valid;
    assign claim_id_o                 = r_claim_id;
    assign complete_ack_o             = r_complete_ack;

endmodule

// File: tb/tb_lagarto_plic_target.sv
// tb/tb_lagarto_plic_target.sv - Directed self-checking bench for lagarto_plic_target.
module tb_lagarto_plic_target;
    import lagarto_plic_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          notif = 1'b0;
    interrupt_id_t id_in = '0;
    logic          pulse;
    logic          meip;
    logic          claim_req = 1'b0;
    logic          claim_valid;
    interrupt_id_t claim_id;
    logic          complete_req = 1'b0;
    interrupt_id_t complete_id = '0;
    logic          ack;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lagarto_plic_target #(
        .NUMBER_OF_INTERRUPT_SOURCES (2),
        .CLAIM_TIMEOUT_CYCLES        (8)
    ) dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .interrupt_notification_i   (notif),
        .interrupt_id_i             (id_in),
        .interrupt_claim_complete_o (pulse),
        .meip_o                     (meip),
        .claim_req_i                (claim_req),
        .claim_valid_o              (claim_valid),
        .claim_id_o                 (claim_id),
        .complete_req_i             (complete_req),
        .complete_id_i              (complete_id),
        .complete_ack_o             (ack),
        .timeout_o                  (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; notif = 1'b1; id_in = 5'd2;
        tick(); tick();
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL reset_meip got %0b want 0", meip); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b want 0", pulse); end
        checks++; if (claim_valid !== 1'b0) begin errors++; $display("FAIL reset_claim_valid got %0b want 0", claim_valid); end
        checks++; if (claim_id !== 5'd0) begin errors++; $display("FAIL reset_claim_id got %0d want 0", claim_id); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b want 0", ack); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b want 0", timeout); end
        rst = 1'b0;
        tick();
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL reset_meip_after got %0b want 1", meip); end
    endtask

    task automatic test_basic_claim();
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        checks++; if (claim_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", claim_valid); end
        checks++; if (claim_id !== 5'd2) begin errors++; $display("FAIL basic_id got %0d want 2", claim_id); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL basic_meip got %0b want 0", meip); end
        tick();
        checks++; if (claim_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0b want 0", claim_valid); end
        checks++; if (claim_id !== 5'd2) begin errors++; $display("FAIL basic_id_hold got %0d want 2", claim_id); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL basic_meip_claimed got %0b want 0", meip); end
    endtask

    task automatic test_matching_complete();
        complete_req = 1'b1; complete_id = 5'd2; tick(); complete_req = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL match_ack got %0b want 1", ack); end
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL match_pulse got %0b want 1", pulse); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL match_meip got %0b want 0", meip); end
        tick();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL match_ack_drop got %0b want 0", ack); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL match_pulse_width got %0b want 0", pulse); end
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL match_meip_reassert got %0b want 1", meip); end
    endtask

    task automatic test_mismatched_complete();
        id_in = 5'd1; claim_req = 1'b1; tick(); claim_req = 1'b0;
        checks++; if (claim_id !== 5'd1) begin errors++; $display("FAIL mis_claim_id got %0d want 1", claim_id); end
        complete_req = 1'b1; complete_id = 5'd2; tick(); complete_req = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mis_ack got %0b want 1", ack); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL mis_pulse got %0b want 0", pulse); end
        complete_req = 1'b1; complete_id = 5'd0; tick(); complete_req = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mis_zero_ack got %0b want 1", ack); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL mis_zero_pulse got %0b want 0", pulse); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL mis_meip got %0b want 0", meip); end
        complete_req = 1'b1; complete_id = 5'd1; tick(); complete_req = 1'b0;
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL mis_then_match_pulse got %0b want 1", pulse); end
        tick();
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL mis_idle_meip got %0b want 1", meip); end
        id_in = 5'd2;
    endtask

    task automatic test_empty_and_nested();
        notif = 1'b0; id_in = 5'd0; tick();
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        checks++; if (claim_valid !== 1'b1) begin errors++; $display("FAIL empty_valid got %0b want 1", claim_valid); end
        checks++; if (claim_id !== 5'd0) begin errors++; $display("FAIL empty_id got %0d want 0", claim_id); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL empty_meip got %0b want 0", meip); end
        notif = 1'b1; id_in = 5'd2; tick();
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        checks++; if (claim_id !== 5'd2) begin errors++; $display("FAIL nested_first_id got %0d want 2", claim_id); end
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        checks++; if (claim_valid !== 1'b1) begin errors++; $display("FAIL nested_valid got %0b want 1", claim_valid); end
        checks++; if (claim_id !== 5'd0) begin errors++; $display("FAIL nested_id got %0d want 0", claim_id); end
        complete_req = 1'b1; complete_id = 5'd2; tick(); complete_req = 1'b0;
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL nested_pulse got %0b want 1", pulse); end
        tick();
    endtask

    task automatic test_simultaneous();
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        claim_req = 1'b1; complete_req = 1'b1; complete_id = 5'd2; tick();
        claim_req = 1'b0; complete_req = 1'b0;
        checks++; if (claim_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got %0b want 1", claim_valid); end
        checks++; if (claim_id !== 5'd0) begin errors++; $display("FAIL simul_id got %0d want 0", claim_id); end
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL simul_ack got %0b want 1", ack); end
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL simul_pulse got %0b want 1", pulse); end
        tick();
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL simul_idle_meip got %0b want 1", meip); end
        claim_req = 1'b1; complete_req = 1'b1; tick();
        claim_req = 1'b0; complete_req = 1'b0;
        checks++; if (claim_id !== 5'd0) begin errors++; $display("FAIL simul_idle_id got %0d want 0", claim_id); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL simul_idle_pulse got %0b want 0", pulse); end
        tick();
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL simul_no_advance_meip got %0b want 1", meip); end
    endtask

    task automatic test_back_to_back();
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        complete_req = 1'b1; complete_id = 5'd2; tick(); complete_req = 1'b0;
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        checks++; if (claim_id !== 5'd2) begin errors++; $display("FAIL b2b_id got %0d want 2", claim_id); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL b2b_pulse got %0b want 0", pulse); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL b2b_meip got %0b want 0", meip); end
        complete_req = 1'b1; tick(); complete_req = 1'b0;
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL b2b_second_pulse got %0b want 1", pulse); end
        tick();
    endtask

    task automatic test_complete_in_idle();
        complete_req = 1'b1; complete_id = 5'd2; tick(); complete_req = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL idle_complete_ack got %0b want 1", ack); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL idle_complete_pulse got %0b want 0", pulse); end
        tick();
    endtask

    task automatic test_reset_mid_claim();
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        tick(); tick();
        rst = 1'b1; #1;
        checks++; if (claim_id !== 5'd0) begin errors++; $display("FAIL rstmid_id got %0d want 0", claim_id); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL rstmid_pulse got %0b want 0", pulse); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL rstmid_meip got %0b want 0", meip); end
        tick(); tick();
        rst = 1'b0;
        complete_req = 1'b1; complete_id = 5'd2; tick(); complete_req = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rstmid_ack got %0b want 1", ack); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL rstmid_stale_pulse got %0b want 0", pulse); end
        tick();
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL rstmid_meip_after got %0b want 1", meip); end
    endtask

`ifdef LAGARTO_PLIC_CLAIM_TIMEOUT_EN
    task automatic test_timeout();
        int seen;
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        repeat (7) tick();
        complete_req = 1'b1; complete_id = 5'd2; tick(); complete_req = 1'b0;
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL tmo_race_pulse got %0b want 1", pulse); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_race_flag got %0b want 0", timeout); end
        tick();
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (pulse === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL tmo_early_pulse got %0d want 0", seen); end
        tick();
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL tmo_pulse got %0b want 1", pulse); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got %0b want 1", timeout); end
        tick();
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width got %0b want 0", pulse); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %0b want 1", timeout); end
        checks++; if (meip !== 1'b1) begin errors++; $display("FAIL tmo_meip got %0b want 1", meip); end
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        repeat (4) tick();
        rst = 1'b1; #1;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_rst_flag got %0b want 0", timeout); end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pulse === 1'b1 || timeout === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL tmo_rst_no_pulse got %0d want 0", seen); end
    endtask
`else
    task automatic test_no_timeout();
        int seen;
        claim_req = 1'b1; tick(); claim_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pulse === 1'b1 || timeout === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL notmo_pulse got %0d want 0", seen); end
        checks++; if (meip !== 1'b0) begin errors++; $display("FAIL notmo_meip got %0b want 0", meip); end
        complete_req = 1'b1; complete_id = 5'd2; tick(); complete_req = 1'b0;
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL notmo_pulse_after got %0b want 1", pulse); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_claim();
        test_matching_complete();
        test_mismatched_complete();
        test_empty_and_nested();
        test_simultaneous();
        test_back_to_back();
        test_complete_in_idle();
        test_reset_mid_claim();
`ifdef LAGARTO_PLIC_CLAIM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lagarto_plic_target.md
# lagarto_plic_target

Hart-side claim/complete controller for the Lagarto PLIC. Consumes the PLIC notification and winning ID, presents a registered machine external interrupt pending bit to the core, and services core claim and complete requests. On a valid complete it returns the single-cycle `interrupt_claim_complete` pulse to the PLIC gateways, closing the gateway handshake.

## Interface
- `NUMBER_OF_INTERRUPT_SOURCES`, default 2: number of sources; bounds legal IDs to 1..N.
- `CLAIM_TIMEOUT_CYCLES`, default 1024: cycles a claim may stay open before forced completion. Used only with the timeout feature.
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `interrupt_notification_i` input 1: PLIC has an enabled pending request.
- `interrupt_id_i` input `interrupt_id_t`: current highest-priority ID; 0 means none.
- `interrupt_claim_complete_o` output 1: one-cycle pulse to the PLIC gateways.
- `meip_o` output 1: registered external interrupt pending bit to the core.
- `claim_req_i` input 1: single-cycle claim-register read strobe.
- `claim_valid_o` output 1: claim response strobe.
- `claim_id_o` output `interrupt_id_t`: claimed ID; 0 means nothing claimed.
- `complete_req_i` input 1: single-cycle complete-register write strobe.
- `complete_id_i` input `interrupt_id_t`: ID written by the core.
- `complete_ack_o` output 1: complete response strobe.
- `timeout_o` output 1: sticky flag set by a forced completion; cleared by reset only.

## Operation
- FSM states are `IDLE`, `CLAIMED` and `COMPLETE`. Register `claimed_id_q` holds the open claim.
- **IDLE**
  - `claim_req_i` with `interrupt_notification_i`=1 and `interrupt_id_i`≠0: latch `claimed_id_q`, respond with that ID, go to CLAIMED.
  - Any other claim: respond with ID 0 and stay in IDLE.
  - `complete_req_i`: acknowledge and ignore; no pulse.
- **CLAIMED**
  - Only one claim may be open. A further claim is answered with ID 0.
  - `complete_req_i` with `complete_id_i`==`claimed_id_q`: acknowledge, go to COMPLETE.
  - Mismatched or out-of-range ID (0 or >N): acknowledge, stay in CLAIMED, no pulse.
- **COMPLETE**
  - Assert `interrupt_claim_complete_o` for exactly one cycle.
  - Clear `claimed_id_q` to 0 and return to IDLE.
  - Requests arriving in this cycle are answered as if the block were in IDLE.
- `meip_o` is `interrupt_notification_i` registered one cycle, qualified by state==IDLE. It is 0 while a claim is open.
- **Simultaneous requests:** if `claim_req_i` and `complete_req_i` arrive together, the complete is serviced normally. The claim is answered with ID 0 and the FSM does not advance because of it.
- Every request gets exactly one response. Nothing is queued.

## Timing
- Reset values: `meip_o`, `interrupt_claim_complete_o`, `claim_valid_o`, `complete_ack_o` and `timeout_o` are 0. `claim_id_o` and `claimed_id_q` are 0 (`NO_INTERRUPT_ID`). FSM is in IDLE.
- Claim latency: `claim_req_i` at cycle t gives `claim_valid_o`/`claim_id_o` at t+1. `claim_id_o` holds its value until the next response.
- Complete latency: `complete_req_i` at t gives `complete_ack_o` at t+1. A matching complete also produces `interrupt_claim_complete_o` at t+1 (COMPLETE state) and IDLE at t+2.
- `meip_o` can re-assert at t+2 after a matching complete.
- Reset in any state aborts the claim immediately. No completion pulse is emitted.

## Configuration
- Macro: `LAGARTO_PLIC_CLAIM_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to CLAIMED and increments every cycle in CLAIMED.
  - When it reaches `CLAIM_TIMEOUT_CYCLES`-1 the FSM goes to COMPLETE, emitting the normal pulse, and sets `timeout_o`.
  - A matching complete in that same cycle takes precedence and `timeout_o` stays unchanged.
  - Counter width is `$clog2(CLAIM_TIMEOUT_CYCLES+1)`.
- **Undefined:** no counter is built, `timeout_o` is tied to 0, and a claim stays open until a matching complete.

## Structure
- `lagarto_plic_pkg` gains:
  - `plic_target_state_t` (IDLE/CLAIMED/COMPLETE);
  - `DEFAULT_CLAIM_TIMEOUT_CYCLES`.
- `lagarto_plic_pkg` reuses the existing `interrupt_id_t` and `NO_INTERRUPT_ID`.
- One sub-module, `lagarto_plic_claim_timer`: counter plus expiry strobe, with start/clear/expire ports. It is instantiated only under `LAGARTO_PLIC_CLAIM_TIMEOUT_EN`.

## Test plan
- **Basic claim:** notification=1, id=2, claim at t → t+1: `claim_valid_o`=1, `claim_id_o`=2. `meip_o`=0 while CLAIMED.
- **Matching complete:** complete id=2 at t → t+1: `complete_ack_o`=1 and one-cycle `interrupt_claim_complete_o`=1. IDLE at t+2.
- **Mismatched complete:** claim id 1, then complete id 2 → ack only, no pulse, still CLAIMED. A subsequent complete id 1 produces the pulse.
- **Empty and nested claims:** claim with notification=0 → `claim_id_o`=0. A second claim while CLAIMED → `claim_id_o`=0.
- **Simultaneous requests:** claim and matching complete in the same cycle → pulse emitted, claim answered with 0, FSM goes to IDLE.
- **Timeout:** with the macro defined and `CLAIM_TIMEOUT_CYCLES`=8, claim and never complete → pulse 8 cycles after entering CLAIMED, `timeout_o`=1 until reset. Repeat with reset asserted mid-claim → outputs 0 and no pulse.
